// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential Booth multiplier and its adder.
package booth_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // {Q[0], q_1} pairs that request an add or a subtract of M
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_seq_multiplier_adder.sv
// 32-bit carry-select adder: 8-bit ripple blocks precompute both carry-in cases.
module carrySelectAdder
    import booth_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int BLK = 8;
    localparam int NB  = WIDTH / BLK;

    logic [NB:0] carry;

    assign carry[0] = cin;

    for (genvar g = 0; g < NB; g++) begin : g_blk
        logic [BLK-1:0] s0;
        logic [BLK-1:0] s1;
        logic           c0;
        logic           c1;

        assign {c0, s0} = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
        assign {c1, s1} = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]} + (BLK+1)'(1);

        assign result[g*BLK +: BLK] = carry[g] ? s1 : s0;
        assign carry[g+1]           = carry[g] ? c1 : c0;
    end

    assign cout     = carry[NB];
    // signed overflow: operands agree in sign but the result does not
    assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential signed radix-2 Booth multiplier; one Booth step per clock through
// a shared carry-select adder. Handshake: start is taken only while ready=1; valid pulses once per product.
module booth_seq_multiplier
    import booth_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    output logic                  ready,
    output logic                  valid,
    output logic [2*WIDTH-1:0]    product
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic             q_1;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] sum;
    logic             ovf;
    logic             sign;

    always_comb begin
        add_b   = '0;
        add_cin = 1'b0;
        case ({q[0], q_1})
            BOOTH_ADD: begin
                add_b   = m;
                add_cin = 1'b0;
            end
            BOOTH_SUB: begin
                add_b   = ~m;
                add_cin = 1'b1;
            end
            default: begin
                add_b   = '0;
                add_cin = 1'b0;
            end
        endcase
    end

    carrySelectAdder u_adder (
        .a        (acc),
        .b        (add_b),
        .cin      (add_cin),
        .result   (sum),
        .cout     (),
        .overflow (ovf)
    );

    // true sign of A+/-M even when the 32-bit sum wraps (e.g. M = 0x80000000)
    assign sign = sum[WIDTH-1] ^ ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ready   <= 1'b1;
            valid   <= 1'b0;
            product <= '0;
            acc     <= '0;
            q       <= '0;
            m       <= '0;
            q_1     <= 1'b0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        m     <= a;
                        q     <= b;
                        acc   <= '0;
                        q_1   <= 1'b0;
                        count <= '0;
                        ready <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= {sign, sum[WIDTH-1:1]};
                    q     <= {sum[0], q[WIDTH-1:1]};
                    q_1   <= q[0];
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH-1)) begin
                        product <= {sign, sum[WIDTH-1:1], sum[0], q[WIDTH-1:1]};
                        valid   <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    valid <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier against a plain signed-multiply reference.
module tb_booth_seq_multiplier;

    localparam int W = 32;
    localparam int LAT = 33;
    localparam int BUDGET = 100;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            ready;
    logic            valid;
    logic [2*W-1:0]  product;

    int checks = 0;
    int passed = 0;
    logic [2*W-1:0] exp_q[$];

    booth_seq_multiplier dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .valid   (valid),
        .product (product)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [2*W-1:0] sx;
        logic signed [2*W-1:0] sy;
        sx = $signed(x);
        sy = $signed(y);
        return sx * sy;
    endfunction

    // Driver: accept one operation, then wait for valid. Cycle 0 is the accept cycle.
    task automatic drive_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                            output int lat, output logic [2*W-1:0] prod, output bit timeout);
        int n;
        @(negedge clk);
        a = xa;
        b = xb;
        start = 1'b1;
        exp_q.push_back(ref_mul(xa, xb));
        n = 0;
        timeout = 1'b0;
        while (!ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        while (!valid && lat < BUDGET) begin
            @(negedge clk);
            lat++;
        end
        timeout = !valid;
        prod = product;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0 || product !== '0)
            $display("FAIL reset_state: ready=%b valid=%b product=%h, required 1 0 0", ready, valid, product);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0)
            $display("FAIL reset_release: ready=%b valid=%b, required 1 0", ready, valid);
        else passed++;
    endtask

    task automatic test_basic();
        @(negedge clk);
        a = 32'd3;
        b = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (ready !== 1'b0) $display("FAIL ready_falls: ready=%b required 0", ready);
        else passed++;
        for (int i = 2; i <= LAT; i++) begin
            @(negedge clk);
            if (i < LAT && valid) begin
                checks++;
                $display("FAIL early_valid: valid seen at cycle %0d, required %0d", i, LAT);
            end
        end
        checks++;
        if (valid !== 1'b1 || product !== 64'h0000_0000_0000_000F)
            $display("FAIL basic_3x5: valid=%b product=%h, required 1 000000000000000f", valid, product);
        else passed++;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || ready !== 1'b1 || product !== 64'hF)
            $display("FAIL valid_one_cycle: valid=%b ready=%b product=%h, required 0 1 f", valid, ready, product);
        else passed++;
    endtask

    task automatic test_directed();
        logic [W-1:0]   ta[5];
        logic [W-1:0]   tb_[5];
        logic [2*W-1:0] tp[5];
        int lat;
        logic [2*W-1:0] prod;
        logic [2*W-1:0] e;
        bit to;
        ta = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000};
        tb_ = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        tp = '{64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 64'h4000_0000_0000_0000,
               64'hC000_0000_8000_0000, 64'h0};
        for (int i = 0; i < 5; i++) begin
            drive_op(ta[i], tb_[i], lat, prod, to);
            e = exp_q.pop_front();
            checks++;
            if (to || lat != LAT || prod !== tp[i] || prod !== e)
                $display("FAIL directed_%0d: lat=%0d product=%h, required lat %0d product %h",
                         i, lat, prod, LAT, tp[i]);
            else passed++;
        end
    endtask

    task automatic test_random();
        int lat;
        logic [2*W-1:0] prod;
        logic [2*W-1:0] e;
        bit to;
        logic [W-1:0] x;
        logic [W-1:0] y;
        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 4 == 1) x = W'($signed($urandom_range(0, 20)) - 10);
            if (i % 4 == 2) y = {1'b1, W'($urandom_range(0, 3))};
            drive_op(x, y, lat, prod, to);
            e = exp_q.pop_front();
            checks++;
            if (to || lat != LAT || prod !== e)
                $display("FAIL random_%0d: a=%h b=%h lat=%0d product=%h, required %h", i, x, y, lat, prod, e);
            else passed++;
        end
    endtask

    task automatic test_busy_start();
        int nvalid;
        logic [2*W-1:0] first;
        @(negedge clk);
        a = 32'd7;
        b = 32'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nvalid = 0;
        first = '0;
        for (int i = 2; i <= 80; i++) begin
            if (i == 10) begin
                a = 32'd9;
                b = 32'd9;
                start = 1'b1;
            end
            @(negedge clk);
            if (i == 10) start = 1'b0;
            if (valid) begin
                nvalid++;
                if (nvalid == 1) first = product;
            end
        end
        checks++;
        if (nvalid != 1 || first !== 64'h2A || product !== 64'h2A)
            $display("FAIL busy_start_ignored: valids=%0d product=%h, required 1 valid product 2a", nvalid, first);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int lat;
        // first op, then hold start from the DONE cycle onwards
        @(negedge clk);
        a = 32'd7;
        b = 32'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!valid && lat < BUDGET) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (!valid || product !== 64'h2A)
            $display("FAIL b2b_first: valid=%b product=%h, required 1 2a", valid, product);
        else passed++;
        a = 32'd9;
        b = 32'd9;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0)
            $display("FAIL b2b_idle_cycle: ready=%b valid=%b, required 1 0", ready, valid);
        else passed++;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (ready !== 1'b0) $display("FAIL b2b_accept: ready=%b required 0", ready);
        else passed++;
        lat = 1;
        while (!valid && lat < BUDGET) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (!valid || lat != LAT || product !== 64'h51)
            $display("FAIL b2b_second: lat=%0d product=%h, required lat %0d product 51", lat, product, LAT);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        int nvalid;
        int lat;
        logic [2*W-1:0] prod;
        logic [2*W-1:0] e;
        bit to;
        @(negedge clk);
        a = 32'h1234_5678;
        b = 32'h0000_0100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0 || product !== '0)
            $display("FAIL reset_midop: ready=%b valid=%b product=%h, required 1 0 0", ready, valid, product);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        checks++;
        if (nvalid != 0 || product !== '0)
            $display("FAIL reset_no_valid: valids=%0d product=%h, required 0 0", nvalid, product);
        else passed++;
        drive_op(32'hFFFF_FFFC, 32'd3, lat, prod, to);
        e = exp_q.pop_front();
        checks++;
        if (to || lat != LAT || prod !== 64'hFFFF_FFFF_FFFF_FFF4 || prod !== e)
            $display("FAIL post_reset: lat=%0d product=%h, required lat %0d product fffffffffffffff4", lat, prod, LAT);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_random();
        test_busy_start();
        test_back_to_back();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
